c17_key_loader: RTL

- Upstream stage of the locked c17 netlist.
- Receives the unlock key serially over a valid/ready handshake and checks it with an even-parity bit.
- On a good check, commits the key into a write-once register that drives keyinput24..26 of c17.
- Until commit, and after repeated bad loads, it drives a fixed decoy key so c17 stays functionally wrong.

---
 rtl/c17_key_loader_if.sv | 30 +++
 rtl/c17_key_loader.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/c17_key_loader_if.sv
// Handshake and status bundle between the key source and the c17 key loader.
// Signal suffixes are from the loader's point of view (_i into it, _o out of it).
interface c17_key_loader_if #(
  parameter int KEY_WIDTH = 3
);
  logic                 start_i;
  logic                 abort_i;
  logic                 s_valid_i;
  logic                 s_bit_i;
  logic                 s_ready_o;
  logic [KEY_WIDTH-1:0] key_out_o;
  logic                 key_committed_o;
  logic                 done_o;
  logic                 err_o;
  logic                 busy_o;
  logic                 lockout_o;
  logic [2:0]           fail_cnt_o;

  modport master (
    output start_i, abort_i, s_valid_i, s_bit_i,
    input  s_ready_o, key_out_o, key_committed_o, done_o, err_o,
           busy_o, lockout_o, fail_cnt_o
  );

  modport slave (
    input  start_i, abort_i, s_valid_i, s_bit_i,
    output s_ready_o, key_out_o, key_committed_o, done_o, err_o,
           busy_o, lockout_o, fail_cnt_o
  );
endinterface

// File: rtl/c17_key_loader.sv
// Serial, parity-checked, write-once key loader feeding keyinput24..26 of c17.
// A decoy key is driven until a verified key is committed; repeated bad loads lock it out.
module c17_key_loader #(
  parameter int                   KEY_WIDTH = 3,
  parameter logic [KEY_WIDTH-1:0] DECOY_KEY = '0,
  parameter int                   MAX_FAIL  = 3
) (
  input logic               clk,
  input logic               rst_n,
  c17_key_loader_if.slave   loader_io
);

  localparam int CNT_W = $clog2(KEY_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    PARITY,
    CHECK,
    COMMITTED,
    LOCKOUT
  } state_e;

  state_e               state_q, state_d;
  logic [KEY_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]     bitCnt_q, bitCnt_d;
  logic                 parity_q, parity_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic                 committed_q, committed_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [2:0]           failCnt_q, failCnt_d;

  logic sReady;
  logic xfer;

  assign sReady = (state_q == SHIFT) || (state_q == PARITY);
  assign xfer   = loader_io.s_valid_i && sReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bitCnt_q    <= '0;
      parity_q    <= 1'b0;
      key_q       <= DECOY_KEY;
      committed_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      failCnt_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bitCnt_q    <= bitCnt_d;
      parity_q    <= parity_d;
      key_q       <= key_d;
      committed_q <= committed_d;
      done_q      <= done_d;
      err_q       <= err_d;
      failCnt_q   <= failCnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bitCnt_d    = bitCnt_q;
    parity_d    = parity_q;
    key_d       = key_q;
    committed_d = committed_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    failCnt_d   = failCnt_q;

    case (state_q)
      IDLE: begin
        if (loader_io.start_i) begin
          state_d  = SHIFT;
          shreg_d  = '0;
          bitCnt_d = '0;
        end
      end

      // abort takes priority so a bit offered in the same cycle is dropped
      SHIFT: begin
        if (loader_io.abort_i) begin
          state_d  = IDLE;
          shreg_d  = '0;
          bitCnt_d = '0;
        end else if (xfer) begin
          shreg_d  = {shreg_q[KEY_WIDTH-2:0], loader_io.s_bit_i};
          bitCnt_d = bitCnt_q + 1'b1;
          if (bitCnt_q == CNT_W'(KEY_WIDTH - 1)) begin
            state_d = PARITY;
          end
        end
      end

      PARITY: begin
        if (loader_io.abort_i) begin
          state_d  = IDLE;
          shreg_d  = '0;
          bitCnt_d = '0;
        end else if (xfer) begin
          parity_d = loader_io.s_bit_i;
          state_d  = CHECK;
        end
      end

      CHECK: begin
        if ((^shreg_q ^ parity_q) == 1'b0) begin
          key_d       = shreg_q;
          committed_d = 1'b1;
          done_d      = 1'b1;
          state_d     = COMMITTED;
        end else begin
          err_d     = 1'b1;
          failCnt_d = (failCnt_q == 3'd7) ? 3'd7 : failCnt_q + 3'd1;
          shreg_d   = '0;
          bitCnt_d  = '0;
          state_d   = (failCnt_d == 3'(MAX_FAIL)) ? LOCKOUT : IDLE;
        end
      end

      COMMITTED: state_d = COMMITTED;
      LOCKOUT:   state_d = LOCKOUT;
      default:   state_d = IDLE;
    endcase
  end

  assign loader_io.s_ready_o       = sReady;
  assign loader_io.key_out_o       = key_q;
  assign loader_io.key_committed_o = committed_q;
  assign loader_io.done_o          = done_q;
  assign loader_io.err_o           = err_q;
  assign loader_io.busy_o          = sReady || (state_q == CHECK);
  assign loader_io.lockout_o       = (state_q == LOCKOUT);
  assign loader_io.fail_cnt_o      = failCnt_q;

endmodule
